// File: rtl/resp_checker_pkg.sv
// Shared types and constants for the response checker: FSM encoding,
// vector count, error-counter width and the one-hot helper.
package resp_checker_pkg;

  localparam int unsigned NUM_VEC = 4;
  localparam int unsigned VEC_W   = 2;
  localparam int unsigned ERR_W   = 3;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [NUM_VEC-1:0] vec_onehot(input logic [VEC_W-1:0] idx);
    logic [NUM_VEC-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/resp_checker_if.sv
// Stimulus/response bundle between the test environment (master) and the
// response checker (slave).
interface resp_checker_if;
  import resp_checker_pkg::*;

  logic                 start;
  logic [NUM_VEC-1:0]   exp_tt;
  logic                 a;
  logic                 b;
  logic                 c;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 timeout;
  logic [ERR_W-1:0]     err_cnt;
  logic [VEC_W-1:0]     first_err_idx;
  logic [NUM_VEC-1:0]   seen;
  logic [NUM_VEC-1:0]   cap_vec;

  modport master (
    output start, exp_tt, a, b, c,
    input  busy, done, pass, timeout, err_cnt, first_err_idx, seen, cap_vec
  );

  modport slave (
    input  start, exp_tt, a, b, c,
    output busy, done, pass, timeout, err_cnt, first_err_idx, seen, cap_vec
  );

endinterface

// File: rtl/resp_checker_stable_detect.sv
// Stability detector: pulses 'stable' on the SETTLE-th consecutive cycle that
// 'vec' has held the same value; 'clear' starts a new run at the current value.
module stable_detect
  import resp_checker_pkg::*;
#(
  parameter int unsigned SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VEC_W-1:0] vec,
  input  logic             clear,
  input  logic             en,
  output logic             stable
);

  // The clearing cycle is the first cycle of a run, so the pulse fires when
  // the counter has already seen SETTLE-2 repeats.
  localparam int unsigned TGT = (SETTLE >= 2) ? SETTLE - 2 : 0;

  logic [VEC_W-1:0] prev;
  logic [7:0]       cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      cnt  <= '0;
    end else if (clear) begin
      prev <= vec;
      cnt  <= '0;
    end else if (en) begin
      if (vec != prev) begin
        prev <= vec;
        cnt  <= '0;
      end else if (cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign stable = en && !clear &&
                  ((SETTLE == 1) || ((vec == prev) && (cnt == 8'(TGT))));

endmodule

// File: rtl/resp_checker.sv
// Response checker: waits for {a,b} to settle, samples c against a latched
// truth table, and reports pass/fail, error count and coverage of all vectors.
module resp_checker
  import resp_checker_pkg::*;
#(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic           clk,
  input logic           rst,
  resp_checker_if.slave bus
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [NUM_VEC-1:0] exp_q, seen_q, cap_q, seen_nxt;
  logic [ERR_W-1:0]   err_q;
  logic [VEC_W-1:0]   first_q, last_idx, vec;
  logic               timeout_q;
  logic [15:0]        tmo_cnt;
  logic               accept, in_check, samp, expire, mismatch, complete;
  logic               det_clear, set_timeout;

  assign vec      = {bus.a, bus.b};
  assign in_check = (state == ST_SETTLE) || (state == ST_HOLD);
  assign accept   = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
  assign expire   = in_check && (tmo_cnt == TMO_LAST);
  assign seen_nxt = seen_q | vec_onehot(vec);
  assign mismatch = bus.c != exp_q[vec];
  assign complete = samp && (seen_nxt == '1);

  stable_detect #(.SETTLE(SETTLE)) u_stable (
    .clk    (clk),
    .rst    (rst),
    .vec    (vec),
    .clear  (det_clear),
    .en     (state == ST_SETTLE),
    .stable (samp)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
    state_nxt   = state;
    det_clear   = 1'b0;
    set_timeout = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_nxt = ST_SETTLE;
          det_clear = 1'b1;
        end
      end
      ST_SETTLE: begin
        // A completing sample wins over a coinciding timeout.
        if (complete) begin
          state_nxt = expire ? ST_DONE : ST_HOLD;
        end else if (expire) begin
          state_nxt   = ST_DONE;
          set_timeout = 1'b1;
        end else if (samp) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (seen_q == '1) begin
          state_nxt = ST_DONE;
        end else if (expire) begin
          state_nxt   = ST_DONE;
          set_timeout = 1'b1;
        end else if (vec != last_idx) begin
          state_nxt = ST_SETTLE;
          det_clear = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q     <= '0;
      seen_q    <= '0;
      cap_q     <= '0;
      err_q     <= '0;
      first_q   <= '0;
      last_idx  <= '0;
      timeout_q <= 1'b0;
      tmo_cnt   <= '0;
    end else if (accept) begin
      exp_q     <= bus.exp_tt;
      seen_q    <= '0;
      cap_q     <= '0;
      err_q     <= '0;
      first_q   <= '0;
      timeout_q <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      if (in_check)    tmo_cnt   <= tmo_cnt + 16'd1;
      if (set_timeout) timeout_q <= 1'b1;
      if (samp) begin
        cap_q[vec] <= bus.c;
        seen_q     <= seen_nxt;
        last_idx   <= vec;
        if (mismatch) begin
          if (err_q == '0)     first_q <= vec;
          if (err_q != ERR_MAX) err_q  <= err_q + ERR_W'(1);
        end
      end
    end
  end

  assign bus.busy          = in_check;
  assign bus.done          = (state == ST_DONE);
  assign bus.pass          = (state == ST_DONE) && (err_q == '0) && !timeout_q;
  assign bus.timeout       = timeout_q;
  assign bus.err_cnt       = err_q;
  assign bus.first_err_idx = first_q;
  assign bus.seen          = seen_q;
  assign bus.cap_vec       = cap_q;

endmodule

// File: tb/tb_resp_checker.sv
// Bench for resp_checker: table-driven directed traces, hand-written corner
// sequences and random traces compared against a trace-level reference model.
module tb_resp_checker;
  import resp_checker_pkg::*;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 1024;
  localparam int MAXLEN  = 1100;

  typedef struct {
    int         done_at;
    logic       timeout;
    logic       pass;
    logic [2:0] err;
    logic [1:0] first;
    logic [3:0] seen;
    logic [3:0] cap;
  } result_t;

  typedef struct {
    logic [3:0] ett;
    logic [7:0] order;
    logic [3:0] bad;
    result_t    exp;
  } vec_rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  resp_checker_if bus();

  resp_checker #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0] tr_vec   [MAXLEN];
  logic       tr_c     [MAXLEN];
  logic       tr_start [MAXLEN];
  logic [3:0] obs_seen [MAXLEN];
  logic [3:0] tr_exp;
  int         tr_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic trace_begin(input logic [3:0] ett);
    tr_exp = ett;
    tr_len = 0;
  endtask

  task automatic add_run(input logic [1:0] v, input int len, input logic cval);
    for (int k = 0; k < len; k++) begin
      if (tr_len < MAXLEN) begin
        tr_vec[tr_len]   = v;
        tr_c[tr_len]     = cval;
        tr_start[tr_len] = (tr_len == 0);
        tr_len++;
      end
    end
  endtask

  task automatic trace_pad();
    while (tr_len < MAXLEN) begin
      tr_vec[tr_len]   = tr_vec[tr_len-1];
      tr_c[tr_len]     = tr_c[tr_len-1];
      tr_start[tr_len] = 1'b0;
      tr_len++;
    end
  endtask

  // Reference model: every maximal run of a constant {a,b} (the start cycle
  // opens the first run) yields one sample on its SETTLE-th cycle, if the run
  // lasts that long. Cycle index 0 is the start cycle; expiry hits at index
  // TIMEOUT, so done shows at TIMEOUT+1 unless all four vectors were seen
  // first, in which case done shows two cycles after the completing sample.
  function automatic result_t model_run();
    result_t    r;
    int         run_start;
    logic [1:0] v;
    r.done_at = TIMEOUT + 1;
    r.timeout = 1'b1;
    r.err     = '0;
    r.first   = '0;
    r.seen    = '0;
    r.cap     = '0;
    run_start = 0;
    for (int i = 0; i < tr_len && i <= TIMEOUT; i++) begin
      if (i > 0 && tr_vec[i] != tr_vec[i-1]) run_start = i;
      if (i - run_start == SETTLE - 1) begin
        v = tr_vec[i];
        if (tr_c[i] != tr_exp[v]) begin
          if (r.err == 0) r.first = v;
          if (r.err != 3'd7) r.err++;
        end
        r.cap[v]  = tr_c[i];
        r.seen[v] = 1'b1;
        if (r.seen == 4'hF) begin
          r.timeout = 1'b0;
          r.done_at = (i + 2 < TIMEOUT + 1) ? i + 2 : TIMEOUT + 1;
          break;
        end
      end
    end
    r.pass = (r.err == 0) && !r.timeout;
    return r;
  endfunction

  // Plays the current trace; inputs change 1 time unit after each rising edge
  // and outputs are sampled at that same point, before the new drive.
  task automatic run_trace(input int abort_at, output result_t r);
    r.done_at = -1;
    for (int i = 0; i < tr_len; i++) begin
      @(posedge clk);
      #1;
      obs_seen[i] = bus.seen;
      if (i == 1) check("busy_after_start", bus.busy, 1);
      if (i > 0 && bus.done === 1'b1) begin
        r.done_at = i;
        break;
      end
      if (i == abort_at) break;
      bus.start        = tr_start[i];
      {bus.a, bus.b}   = tr_vec[i];
      bus.c            = tr_c[i];
      bus.exp_tt       = (i == 0) ? tr_exp : 4'($urandom);
    end
    bus.start = 1'b0;
    r.timeout = bus.timeout;
    r.pass    = bus.pass;
    r.err     = bus.err_cnt;
    r.first   = bus.first_err_idx;
    r.seen    = bus.seen;
    r.cap     = bus.cap_vec;
  endtask

  task automatic compare(input string tag, input result_t got, input result_t exp);
    check({tag, ".done_at"}, got.done_at, exp.done_at);
    check({tag, ".timeout"}, got.timeout, exp.timeout);
    check({tag, ".pass"},    got.pass,    exp.pass);
    check({tag, ".err_cnt"}, got.err,     exp.err);
    check({tag, ".first"},   got.first,   exp.first);
    check({tag, ".seen"},    got.seen,    exp.seen);
    check({tag, ".cap_vec"}, got.cap,     exp.cap);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},    bus.busy,          0);
    check({tag, ".done"},    bus.done,          0);
    check({tag, ".pass"},    bus.pass,          0);
    check({tag, ".timeout"}, bus.timeout,       0);
    check({tag, ".err_cnt"}, bus.err_cnt,       0);
    check({tag, ".first"},   bus.first_err_idx, 0);
    check({tag, ".seen"},    bus.seen,          0);
    check({tag, ".cap_vec"}, bus.cap_vec,       0);
  endtask

  task automatic build_table_trace(input vec_rec_t rec);
    logic [1:0] v;
    trace_begin(rec.ett);
    for (int k = 0; k < 4; k++) begin
      v = rec.order[2*k +: 2];
      add_run(v, 8, rec.ett[v] ^ rec.bad[v]);
    end
    trace_pad();
  endtask

  vec_rec_t tbl [5];
  result_t  got, exp;

  initial begin
    // order packs the visiting sequence, first vector in bits [1:0].
    tbl[0] = '{4'b1000, 8'hE4, 4'b0000, '{29, 1'b0, 1'b1, 3'd0, 2'd0, 4'hF, 4'b1000}};
    tbl[1] = '{4'b1000, 8'hE4, 4'b0010, '{29, 1'b0, 1'b0, 3'd1, 2'd1, 4'hF, 4'b1010}};
    tbl[2] = '{4'b1110, 8'h1B, 4'b0000, '{29, 1'b0, 1'b1, 3'd0, 2'd0, 4'hF, 4'b1110}};
    tbl[3] = '{4'b0110, 8'hE4, 4'b1001, '{29, 1'b0, 1'b0, 3'd2, 2'd0, 4'hF, 4'b1111}};
    tbl[4] = '{4'b0110, 8'h72, 4'b1000, '{29, 1'b0, 1'b0, 3'd1, 2'd3, 4'hF, 4'b1110}};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.exp_tt = '0;
    bus.a = 1'b0;
    bus.b = 1'b0;
    bus.c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    for (int t = 0; t < 5; t++) begin
      build_table_trace(tbl[t]);
      run_trace(-1, got);
      compare($sformatf("table%0d", t), got, tbl[t].exp);
    end

    // Fast toggling must not produce samples; only the later 8-cycle holds do.
    trace_begin(4'b1000);
    for (int k = 0; k < 8; k++) add_run(2'(k % 4), 3, tr_exp[k % 4]);
    for (int v = 0; v < 4; v++) add_run(2'(v), 8, tr_exp[v]);
    trace_pad();
    exp = model_run();
    run_trace(-1, got);
    check("toggle.seen_at_24", obs_seen[24], 0);
    check("toggle.done_at_const", got.done_at, 53);
    compare("toggle", got, exp);

    // Holding one vector forever ends in timeout.
    trace_begin(4'b1000);
    add_run(2'd0, MAXLEN, 1'b0);
    run_trace(-1, got);
    compare("timeout", got, '{TIMEOUT + 1, 1'b1, 1'b0, 3'd0, 2'd0, 4'b0001, 4'b0000});

    // Revisit of 00 with a wrong response after a correct first sample.
    trace_begin(4'b1000);
    add_run(2'd0, 8, 1'b0);
    add_run(2'd1, 8, 1'b0);
    add_run(2'd0, 8, 1'b1);
    add_run(2'd2, 8, 1'b0);
    add_run(2'd3, 8, 1'b1);
    trace_pad();
    run_trace(-1, got);
    compare("revisit", got, '{37, 1'b0, 1'b0, 3'd1, 2'd0, 4'hF, 4'b1001});

    // Ten wrong samples saturate the error count at 7.
    trace_begin(4'b1000);
    for (int k = 0; k < 10; k++) add_run(2'(k % 2), 5, 1'b1);
    add_run(2'd2, 5, 1'b0);
    add_run(2'd3, 5, 1'b1);
    trace_pad();
    run_trace(-1, got);
    compare("saturate", got, '{60, 1'b0, 1'b0, 3'd7, 2'd0, 4'hF, 4'b1011});

    // Reset in the middle of vector 10, with start asserted alongside it.
    build_table_trace(tbl[0]);
    run_trace(18, got);
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("mid_reset");
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_reset.done", bus.done, 0);
    check("post_reset.busy", bus.busy, 0);
    run_trace(-1, got);
    compare("after_reset", got, tbl[0].exp);

    // Random traces: random runs, occasional wrong c, ignored start pulses.
    for (int t = 0; t < 8; t++) begin
      int target;
      trace_begin(4'($urandom));
      target = $urandom_range(60, 200);
      while (tr_len < target) add_run(2'($urandom), $urandom_range(1, 7), 1'b0);
      for (int i = 0; i < tr_len; i++) begin
        tr_c[i] = tr_exp[tr_vec[i]] ^ ($urandom_range(0, 9) == 0);
        if (i > 0) tr_start[i] = ($urandom_range(0, 29) == 0);
      end
      trace_pad();
      exp = model_run();
      run_trace(-1, got);
      compare($sformatf("random%0d", t), got, exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/resp_checker.md
RESP_CHECKER -- requirements
Module: resp_checker

Interface
REQ-001 Parameter SETTLE, default 4: consecutive cycles {a,b} must be stable before c is sampled; legal range 1..255.
REQ-002 Parameter TIMEOUT, default 1024: cycles from start until the check is abandoned; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse that begins a check; honoured only in IDLE or DONE.
REQ-006 exp_tt  input  4  expected truth table; exp_tt[{a,b}] is the expected c; sampled on the accepted start and held internally.
REQ-007 a, b  input  1 each  stimulus observed at the DUT inputs.
REQ-008 c  input  1  DUT response.
REQ-009 busy  output  1  high in SETTLE and HOLD.
REQ-010 done  output  1  high in DONE.
REQ-011 pass  output  1  valid while done; 1 iff err_cnt==0 and timeout==0.
REQ-012 timeout  output  1  check ended by TIMEOUT expiry.
REQ-013 err_cnt  output  3  mismatch count, saturating at 7.
REQ-014 first_err_idx  output  2  {a,b} index of the first mismatch; valid when err_cnt!=0.
REQ-015 seen  output  4  bit i set once vector i has been sampled.
REQ-016 cap_vec  output  4  bit i holds the last sampled c for vector i.

Function
REQ-017 FSM states: IDLE, SETTLE, HOLD, DONE.
REQ-018 Accepted start: clear seen, cap_vec, err_cnt, first_err_idx, timeout, settle and timeout counters; latch exp_tt; load prev={a,b}; go to SETTLE.
REQ-019 SETTLE, {a,b}!=prev: prev<={a,b}, settle counter<=0.
REQ-020 SETTLE, {a,b}==prev: increment settle counter; when it reaches SETTLE-1, sample c that cycle and go to HOLD.
REQ-021 Sample of index i: cap_vec[i]<=c; seen[i]<=1; if c!=exp_tt[i], increment err_cnt (saturating) and set first_err_idx=i if err_cnt was 0.
REQ-022 Revisiting an already-seen vector re-samples and re-compares; seen is unchanged and mismatches count again.
REQ-023 HOLD: if seen==4'hF, go to DONE next cycle; otherwise wait for {a,b}!=prev, then update prev, clear the settle counter and go to SETTLE.
REQ-024 The timeout counter increments every cycle in SETTLE and HOLD; on reaching TIMEOUT-1, go to DONE with timeout=1.
REQ-025 If a sample completing seen==4'hF coincides with timeout expiry, the sample is recorded, timeout=0, and the FSM goes to DONE.
REQ-026 Latency: c is sampled on the SETTLE-th consecutive stable cycle; done rises 2 cycles after the sample that completes seen.
REQ-027 DONE holds all outputs stable until start or rst; start in DONE behaves as in REQ-018.
REQ-028 start in SETTLE or HOLD is ignored.

Reset
REQ-029 rst has priority over start: state<=IDLE, and busy, done, pass, timeout, err_cnt, first_err_idx, seen, cap_vec all 0.
REQ-030 rst mid-check abandons the check with no DONE pulse; a new start is required.

Structure
REQ-031 State encoding, NUM_VEC=4 and the err_cnt width belong in the shared package resp_checker_pkg.
REQ-032 The settle counter/stability detector is one sub-module, stable_detect (inputs: vector, clear; output: stable pulse).
REQ-033 The design has no combinational path from a, b or c to any output.

Verification (SETTLE=4, TIMEOUT=1024, exp_tt=4'b1000 AND table)
REQ-034 Drive 00, 01, 10, 11 for 8 cycles each with c=a&b -> done=1, pass=1, err_cnt=0, seen=4'hF, cap_vec=4'b1000.
REQ-035 Same sequence, but c forced 1 on vector 01 -> pass=0, err_cnt=1, first_err_idx=1, cap_vec=4'b1010.
REQ-036 {a,b} toggles every 3 cycles for the first 24 cycles, then 8-cycle holds -> no samples during toggling; samples only after 4 stable cycles.
REQ-037 Hold 00 indefinitely -> done at TIMEOUT, timeout=1, pass=0, seen=4'b0001.
REQ-038 Assert rst during vector 10 -> all outputs 0, state IDLE; a fresh start followed by the full sequence gives pass=1.
REQ-039 Revisit 00 with c=1 after a correct sample -> err_cnt=1, first_err_idx=0, seen[0] remains 1.
